// File: rtl/store_write_port.sv
// store_write_port: drains one store-buffer entry at a time onto a
// single-beat AXI write (AW/W/B), holding cache_is_busy until B returns.
// Also tracks completed stores and the first erroring store address.
module store_write_port #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             in_store_en,
  input  logic [31:0]      in_store_addr,
  input  logic [31:0]      in_store_data,
  input  logic [3:0]       in_store_rwen,
  input  logic             in_store_uncache,
  input  logic             in_store_rw,
  output logic             cache_is_busy,
  output logic             awvalid,
  input  logic             awready,
  output logic [31:0]      awaddr,
  output logic [2:0]       awsize,
  output logic [3:0]       awcache,
  output logic             wvalid,
  input  logic             wready,
  output logic [31:0]      wdata,
  output logic [3:0]       wstrb,
  output logic             wlast,
  input  logic             bvalid,
  output logic             bready,
  input  logic [1:0]       bresp,
  input  logic             err_clr,
  output logic             store_error,
  output logic [31:0]      store_err_addr,
  output logic [CNT_W-1:0] store_done_cnt,
  output logic             port_idle
);

  typedef enum logic [1:0] {IDLE, ADDR_DATA, RESP} state_t;

  state_t      state, state_nxt;
  logic [31:0] addr_q, data_q;
  logic [3:0]  rwen_q;
  logic        uncache_q;
  logic        accept, aw_hs, w_hs, b_hs, ad_done, new_err;

  // Only real writes with at least one byte lane enabled are taken;
  // everything else slides past while we are not busy.
  assign accept  = (state == IDLE) && !cache_is_busy && in_store_en &&
                   in_store_rw && (in_store_rwen != 4'b0000);
  assign aw_hs   = awvalid & awready;
  assign w_hs    = wvalid & wready;
  assign b_hs    = bvalid & bready;
  // Both channels have retired once their valids have dropped.
  assign ad_done = !awvalid && !wvalid;
  // A fresh error is captured if none is held, or if the held one is
  // being cleared on this same edge (the new error wins).
  assign new_err = b_hs && (bresp != 2'b00) && (!store_error || err_clr);

  assign awaddr    = addr_q;
  assign wdata     = data_q;
  assign wstrb     = rwen_q;
  assign wlast     = wvalid;
  assign awcache   = uncache_q ? 4'b0000 : 4'b1111;
  assign port_idle = (state == IDLE) && !cache_is_busy;

  // Transfer size derived from the byte-enable pattern.
  always_comb begin
    awsize = 3'd2;
    case (rwen_q)
      4'b1111:                            awsize = 3'd2;
      4'b0011, 4'b1100:                   awsize = 3'd1;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: awsize = 3'd0;
      default:                            awsize = 3'd2;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (accept)  state_nxt = ADDR_DATA;
      ADDR_DATA: if (ad_done) state_nxt = RESP;
      RESP:      if (b_hs)    state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Payload capture and handshake control; payload only moves on accept,
  // so AW/W stay stable while their valids wait for ready.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      addr_q        <= '0;
      data_q        <= '0;
      rwen_q        <= '0;
      uncache_q     <= 1'b0;
      cache_is_busy <= 1'b0;
      awvalid       <= 1'b0;
      wvalid        <= 1'b0;
      bready        <= 1'b0;
    end else begin
      if (accept) begin
        addr_q    <= in_store_addr;
        data_q    <= in_store_data;
        rwen_q    <= in_store_rwen;
        uncache_q <= in_store_uncache;
      end
      if (accept)    cache_is_busy <= 1'b1;
      else if (b_hs) cache_is_busy <= 1'b0;
      if (accept)     awvalid <= 1'b1;
      else if (aw_hs) awvalid <= 1'b0;
      if (accept)    wvalid <= 1'b1;
      else if (w_hs) wvalid <= 1'b0;
      if (state == ADDR_DATA && ad_done) bready <= 1'b1;
      else if (b_hs)                     bready <= 1'b0;
    end
  end

  // Completion counter and sticky error capture.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      store_done_cnt <= '0;
      store_error    <= 1'b0;
      store_err_addr <= '0;
    end else begin
      if (b_hs) store_done_cnt <= store_done_cnt + CNT_W'(1);
      if (new_err) begin
        store_error    <= 1'b1;
        store_err_addr <= addr_q;
      end else if (err_clr) begin
        store_error    <= 1'b0;
        store_err_addr <= '0;
      end
    end
  end

endmodule
